// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap controller beside the execute stage.
// Each cycle it resolves the presented instruction into a CSR access, a trap, an mret or a plain retire.
module csr_trap_unit #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] HART_ID     = '0,
    parameter bit              VECTORED_EN = 1'b1,
    parameter logic [XLEN-1:0] MISA_VAL    = {((XLEN == 64) ? 2'b10 : 2'b01), {(XLEN-2){1'b0}}}
                                             | XLEN'(9'd256)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    input  logic [XLEN-1:0] inst_addr,
    input  logic [11:0]     csr_index,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            csr_wr_suppress,
    input  logic            inst_ecall,
    input  logic            inst_ebreak,
    input  logic            inst_mret,
    input  logic            inst_illegal,
    input  logic [31:0]     inst_bits,
    input  logic            irq_msip,
    input  logic            irq_mtip,
    input  logic            irq_meip,
    output logic [XLEN-1:0] csr_rdata,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            retire,
    output logic            illegal_csr
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [XLEN-3:0] mtvec_base_q, mtvec_base_d;
    logic            mtvec_mode_q, mtvec_mode_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mcycle_q, mcycle_d;
    logic [XLEN-1:0] minstret_q, minstret_d;
    // Interrupt enable and pending samples, ordered {MEI, MTI, MSI}.
    logic [2:0]      mie_q, mie_d;
    logic [2:0]      ip_q, ip_d;

    logic [XLEN-1:0] mstatus_rd_s, mie_rd_s, mip_rd_s, mtvec_rd_s;
    logic [XLEN-1:0] csr_old_s, csr_wval_s;
    logic            csr_known_s, csr_ro_s;
    logic            illegal_csr_s, csr_we_s;
    logic [2:0]      irq_pend_s;
    logic            irq_take_s, trap_s, trap_int_s, mret_take_s, retire_s;
    logic [3:0]      trap_cause_s;
    logic [XLEN-1:0] trap_tval_s, trap_pc_s;

    // Assemble the architectural read views of the partially implemented CSRs.
    always_comb begin
        mstatus_rd_s        = '0;
        mstatus_rd_s[3]     = mstatus_mie_q;
        mstatus_rd_s[7]     = mstatus_mpie_q;
        mstatus_rd_s[12:11] = 2'b11;
        mie_rd_s            = '0;
        mie_rd_s[3]         = mie_q[0];
        mie_rd_s[7]         = mie_q[1];
        mie_rd_s[11]        = mie_q[2];
        mip_rd_s            = '0;
        mip_rd_s[3]         = ip_q[0];
        mip_rd_s[7]         = ip_q[1];
        mip_rd_s[11]        = ip_q[2];
        mtvec_rd_s          = {mtvec_base_q, 1'b0, mtvec_mode_q};
    end

    // Decode the CSR index into its old value and access class.
    always_comb begin
        csr_old_s   = '0;
        csr_known_s = 1'b1;
        csr_ro_s    = 1'b0;
        case (csr_index)
            A_MSTATUS:  csr_old_s = mstatus_rd_s;
            A_MIE:      csr_old_s = mie_rd_s;
            A_MTVEC:    csr_old_s = mtvec_rd_s;
            A_MSCRATCH: csr_old_s = mscratch_q;
            A_MEPC:     csr_old_s = mepc_q;
            A_MCAUSE:   csr_old_s = mcause_q;
            A_MTVAL:    csr_old_s = mtval_q;
            A_MIP:      csr_old_s = mip_rd_s;
            A_MCYCLE:   csr_old_s = mcycle_q;
            A_MINSTRET: csr_old_s = minstret_q;
            A_MISA: begin
                csr_old_s = MISA_VAL;
                csr_ro_s  = 1'b1;
            end
            A_MVENDORID, A_MARCHID, A_MIMPID: csr_ro_s = 1'b1;
            A_MHARTID: begin
                csr_old_s = HART_ID;
                csr_ro_s  = 1'b1;
            end
            default: csr_known_s = 1'b0;
        endcase
    end

    // Read-modify-write value for the three CSR operations.
    always_comb begin
        case (csr_op)
            2'b01:   csr_wval_s = csr_wdata;
            2'b10:   csr_wval_s = csr_old_s | csr_wdata;
            2'b11:   csr_wval_s = csr_old_s & ~csr_wdata;
            default: csr_wval_s = csr_old_s;
        endcase
    end

    assign illegal_csr_s = inst_valid & (csr_op != 2'b00)
                           & (~csr_known_s | (csr_ro_s & ~csr_wr_suppress));
    assign irq_pend_s    = mie_q & ip_q;
    assign irq_take_s    = inst_valid & mstatus_mie_q & (|irq_pend_s);
    assign trap_s        = irq_take_s
                           | (inst_valid & (inst_illegal | illegal_csr_s | inst_ecall | inst_ebreak));
    assign mret_take_s   = inst_valid & inst_mret & ~trap_s;
    assign retire_s      = inst_valid & ~trap_s;
    assign csr_we_s      = inst_valid & (csr_op != 2'b00) & ~csr_wr_suppress
                           & ~illegal_csr_s & ~trap_s;

    // Pick the highest-priority trap cause and its mtval payload.
    always_comb begin
        trap_int_s   = 1'b0;
        trap_cause_s = 4'd0;
        trap_tval_s  = '0;
        if (irq_take_s) begin
            trap_int_s = 1'b1;
            if (irq_pend_s[2]) begin
                trap_cause_s = 4'd11;
            end else if (irq_pend_s[0]) begin
                trap_cause_s = 4'd3;
            end else begin
                trap_cause_s = 4'd7;
            end
        end else if (inst_illegal || illegal_csr_s) begin
            trap_cause_s = 4'd2;
            trap_tval_s  = XLEN'(inst_bits);
        end else if (inst_ecall) begin
            trap_cause_s = 4'd11;
        end else if (inst_ebreak) begin
            trap_cause_s = 4'd3;
            trap_tval_s  = inst_addr;
        end else begin
            trap_cause_s = 4'd0;
        end
    end

    // Only interrupts are vectored; exceptions always land on the base.
    assign trap_pc_s = {mtvec_base_q, 2'b00}
                       + ((trap_int_s && mtvec_mode_q) ? XLEN'({trap_cause_s, 2'b00}) : '0);

    assign csr_rdata   = illegal_csr_s ? '0 : csr_old_s;
    assign redirect    = trap_s | mret_take_s;
    assign redirect_pc = trap_s ? trap_pc_s : (mret_take_s ? mepc_q : '0);
    assign retire      = retire_s;
    assign illegal_csr = illegal_csr_s;

    // Next-state: reset, then trap entry, otherwise CSR write and mret.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mtvec_base_d   = mtvec_base_q;
        mtvec_mode_d   = mtvec_mode_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mscratch_d     = mscratch_q;
        mie_d          = mie_q;
        ip_d           = {irq_meip, irq_mtip, irq_msip};
        mcycle_d       = mcycle_q + XLEN'(1'b1);
        minstret_d     = retire_s ? (minstret_q + XLEN'(1'b1)) : minstret_q;
        if (rst) begin
            mstatus_mie_d  = 1'b0;
            mstatus_mpie_d = 1'b0;
            mtvec_base_d   = '0;
            mtvec_mode_d   = 1'b0;
            mepc_d         = '0;
            mcause_d       = '0;
            mtval_d        = '0;
            mscratch_d     = '0;
            mie_d          = 3'b000;
            ip_d           = 3'b000;
            mcycle_d       = '0;
            minstret_d     = '0;
        end else if (trap_s) begin
            mepc_d             = {inst_addr[XLEN-1:2], 2'b00};
            mcause_d           = XLEN'(trap_cause_s);
            mcause_d[XLEN-1]   = trap_int_s;
            mtval_d            = trap_tval_s;
            mstatus_mpie_d     = mstatus_mie_q;
            mstatus_mie_d      = 1'b0;
        end else begin
            mtvec_base_d = (csr_we_s && csr_index == A_MTVEC) ? csr_wval_s[XLEN-1:2] : mtvec_base_q;
            mtvec_mode_d = (csr_we_s && csr_index == A_MTVEC) ? (VECTORED_EN & csr_wval_s[0])
                                                               : mtvec_mode_q;
            mepc_d       = (csr_we_s && csr_index == A_MEPC) ? {csr_wval_s[XLEN-1:2], 2'b00} : mepc_q;
            mcause_d     = (csr_we_s && csr_index == A_MCAUSE) ? csr_wval_s : mcause_q;
            mtval_d      = (csr_we_s && csr_index == A_MTVAL) ? csr_wval_s : mtval_q;
            mscratch_d   = (csr_we_s && csr_index == A_MSCRATCH) ? csr_wval_s : mscratch_q;
            mie_d        = (csr_we_s && csr_index == A_MIE)
                           ? {csr_wval_s[11], csr_wval_s[7], csr_wval_s[3]} : mie_q;
            mcycle_d     = (csr_we_s && csr_index == A_MCYCLE) ? csr_wval_s : mcycle_d;
            minstret_d   = (csr_we_s && csr_index == A_MINSTRET) ? csr_wval_s : minstret_d;
            // mret takes precedence over a same-cycle mstatus write.
            mstatus_mie_d  = mret_take_s ? mstatus_mpie_q
                           : ((csr_we_s && csr_index == A_MSTATUS) ? csr_wval_s[3] : mstatus_mie_q);
            mstatus_mpie_d = mret_take_s ? 1'b1
                           : ((csr_we_s && csr_index == A_MSTATUS) ? csr_wval_s[7] : mstatus_mpie_q);
        end
    end

    // State registers; reset is folded into the next-state logic.
    always_ff @(posedge clk) begin
        mstatus_mie_q  <= mstatus_mie_d;
        mstatus_mpie_q <= mstatus_mpie_d;
        mtvec_base_q   <= mtvec_base_d;
        mtvec_mode_q   <= mtvec_mode_d;
        mepc_q         <= mepc_d;
        mcause_q       <= mcause_d;
        mtval_q        <= mtval_d;
        mscratch_q     <= mscratch_d;
        mie_q          <= mie_d;
        ip_q           <= ip_d;
        mcycle_q       <= mcycle_d;
        minstret_q     <= minstret_d;
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: directed literal scenarios, then random traffic checked
// every cycle against a CSR-table reference model.
module tb_csr_trap_unit;

    localparam logic [63:0] HART = 64'd5;
    localparam logic [63:0] MISA = 64'h8000_0000_0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid = 1'b0;
    logic [63:0] inst_addr = 64'd0;
    logic [11:0] csr_index = 12'd0;
    logic [1:0]  csr_op = 2'd0;
    logic [63:0] csr_wdata = 64'd0;
    logic        csr_wr_suppress = 1'b0;
    logic        inst_ecall = 1'b0, inst_ebreak = 1'b0, inst_mret = 1'b0, inst_illegal = 1'b0;
    logic [31:0] inst_bits = 32'd0;
    logic        irq_msip = 1'b0, irq_mtip = 1'b0, irq_meip = 1'b0;
    logic [63:0] csr_rdata, redirect_pc, nv_rdata, nv_pc;
    logic        redirect, retire, illegal_csr, nv_redirect, nv_retire, nv_illegal;

    int total = 0;
    int bad = 0;
    logic [2:0] irq_v = 3'b000;

    csr_trap_unit #(.XLEN(64), .HART_ID(HART), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_addr(inst_addr),
        .csr_index(csr_index), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_wr_suppress(csr_wr_suppress), .inst_ecall(inst_ecall), .inst_ebreak(inst_ebreak),
        .inst_mret(inst_mret), .inst_illegal(inst_illegal), .inst_bits(inst_bits),
        .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
        .csr_rdata(csr_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .retire(retire), .illegal_csr(illegal_csr));

    csr_trap_unit #(.XLEN(64), .HART_ID(HART), .VECTORED_EN(1'b0)) dut_nv (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_addr(inst_addr),
        .csr_index(csr_index), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_wr_suppress(csr_wr_suppress), .inst_ecall(inst_ecall), .inst_ebreak(inst_ebreak),
        .inst_mret(inst_mret), .inst_illegal(inst_illegal), .inst_bits(inst_bits),
        .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
        .csr_rdata(nv_rdata), .redirect(nv_redirect), .redirect_pc(nv_pc),
        .retire(nv_retire), .illegal_csr(nv_illegal));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: CSR table keyed by address ----------------
    logic [63:0] mv [logic [11:0]];
    logic [63:0] wmask [logic [11:0]];
    logic [63:0] m_ip;
    bit          m_ok = 1'b0;

    function automatic bit is_ro(input logic [11:0] a);
        return (a == 12'h301) || (a >= 12'hF11 && a <= 12'hF14);
    endfunction

    function automatic bit is_known(input logic [11:0] a);
        return is_ro(a) || wmask.exists(a);
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return mv[a] | 64'h1800;
            12'h301: return MISA;
            12'hF14: return HART;
            12'h344: return m_ip;
            default: return wmask.exists(a) ? mv[a] : 64'd0;
        endcase
    endfunction

    // Compare process: expected outputs from the model, then advance the model.
    initial begin
        logic [63:0] pend, cause, wv, old, e_pc;
        bit ill, intr, trap, ret, mr;
        wmask[12'h300] = 64'h88;
        wmask[12'h304] = 64'h888;
        wmask[12'h305] = ~64'h2;
        wmask[12'h340] = ~64'h0;
        wmask[12'h341] = ~64'h3;
        wmask[12'h342] = ~64'h0;
        wmask[12'h343] = ~64'h0;
        wmask[12'h344] = 64'h0;
        wmask[12'hB00] = ~64'h0;
        wmask[12'hB02] = ~64'h0;
        forever begin
            @(negedge clk);
            if (m_ok) begin
                ill  = inst_valid && csr_op != 2'b00
                       && (!is_known(csr_index) || (is_ro(csr_index) && !csr_wr_suppress));
                pend = mv[12'h304] & m_ip;
                intr = inst_valid && mv[12'h300][3] && pend != 64'd0;
                trap = intr || (inst_valid && (inst_illegal || ill || inst_ecall || inst_ebreak));
                if (intr) cause = pend[11] ? 64'd11 : (pend[3] ? 64'd3 : 64'd7);
                else if (inst_illegal || ill) cause = 64'd2;
                else if (inst_ecall) cause = 64'd11;
                else cause = 64'd3;
                ret  = inst_valid && !trap;
                mr   = ret && inst_mret;
                e_pc = trap ? ((mv[12'h305] & ~64'h3) + ((intr && mv[12'h305][0]) ? 4 * cause : 64'd0))
                            : mv[12'h341];
                check("rdata", csr_rdata, ill ? 64'd0 : m_read(csr_index));
                check("illegal_csr", {63'd0, illegal_csr}, {63'd0, ill});
                check("redirect", {63'd0, redirect}, {63'd0, trap || mr});
                check("retire", {63'd0, retire}, {63'd0, ret});
                if (trap || mr) check("redirect_pc", redirect_pc, e_pc);
                old = m_read(csr_index);
                mv[12'hB00] = mv[12'hB00] + 64'd1;
                if (ret) mv[12'hB02] = mv[12'hB02] + 64'd1;
                if (trap) begin
                    mv[12'h341] = inst_addr & ~64'h3;
                    mv[12'h342] = intr ? (cause | 64'h8000_0000_0000_0000) : cause;
                    mv[12'h343] = intr ? 64'd0 : (cause == 64'd2) ? {32'd0, inst_bits}
                                : (cause == 64'd3) ? inst_addr : 64'd0;
                    mv[12'h300] = mv[12'h300][3] ? 64'h80 : 64'h0;
                end else begin
                    if (inst_valid && csr_op != 2'b00 && !csr_wr_suppress && wmask.exists(csr_index)) begin
                        wv = (csr_op == 2'b01) ? csr_wdata
                           : (csr_op == 2'b10) ? (old | csr_wdata) : (old & ~csr_wdata);
                        mv[csr_index] = wv & wmask[csr_index];
                    end
                    if (mr) mv[12'h300] = 64'h80 | (mv[12'h300][7] ? 64'h8 : 64'h0);
                end
                m_ip = {52'd0, irq_meip, 3'd0, irq_mtip, 3'd0, irq_msip, 3'd0};
            end
            if (rst) begin
                foreach (wmask[k]) mv[k] = 64'd0;
                m_ip = 64'd0;
                m_ok = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit r, input bit v, input logic [63:0] pc, input logic [11:0] idx,
                        input logic [1:0] op, input logic [63:0] wd, input bit sup,
                        input logic [3:0] cls, input logic [31:0] bits);
        @(posedge clk);
        #1;
        rst = r; inst_valid = v; inst_addr = pc; csr_index = idx; csr_op = op;
        csr_wdata = wd; csr_wr_suppress = sup; inst_bits = bits;
        {inst_illegal, inst_mret, inst_ebreak, inst_ecall} = cls;
        {irq_meip, irq_mtip, irq_msip} = irq_v;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic [11:0] idx);
        step(1'b0, 1'b0, 64'd0, idx, 2'b00, 64'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic csrw(input logic [11:0] idx, input logic [1:0] op, input logic [63:0] wd);
        step(1'b0, 1'b1, 64'h40, idx, op, wd, 1'b0, 4'd0, 32'd0);
    endtask

    initial begin
        logic [11:0] idx_tab [0:15];
        logic [3:0]  cls;
        logic [1:0]  op;
        idx_tab = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                    12'h344, 12'hB00, 12'hB02, 12'hF11, 12'hF14, 12'h7C0, 12'h000, 12'h345};

        step(1'b1, 1'b0, 64'd0, 12'h300, 2'b00, 64'd0, 1'b0, 4'd0, 32'd0);
        step(1'b1, 1'b0, 64'd0, 12'h300, 2'b00, 64'd0, 1'b0, 4'd0, 32'd0);
        idle(12'h300);
        check("rst_mstatus", csr_rdata, 64'h1800);
        check("rst_redirect", {63'd0, redirect}, 64'd0);
        check("rst_retire", {63'd0, retire}, 64'd0);
        check("rst_illegal", {63'd0, illegal_csr}, 64'd0);
        idle(12'h301);
        check("misa", csr_rdata, MISA);
        idle(12'hF14);
        check("mhartid", csr_rdata, HART);

        // Vectored timer interrupt.
        csrw(12'h305, 2'b01, 64'h8000_0001);
        idle(12'h305);
        check("mtvec_vec", csr_rdata, 64'h8000_0001);
        check("mtvec_novec", nv_rdata, 64'h8000_0000);
        csrw(12'h300, 2'b10, 64'h8);
        irq_v = 3'b010;
        csrw(12'h304, 2'b01, 64'h80);
        step(1'b0, 1'b1, 64'h100, 12'h000, 2'b00, 64'd0, 1'b0, 4'd0, 32'd0);
        check("mti_redirect", {63'd0, redirect}, 64'd1);
        check("mti_pc", redirect_pc, 64'h8000_001C);
        check("mti_pc_novec", nv_pc, 64'h8000_0000);
        check("mti_retire", {63'd0, retire}, 64'd0);
        irq_v = 3'b000;
        idle(12'h342);
        check("mti_mcause", csr_rdata, 64'h8000_0000_0000_0007);
        idle(12'h341);
        check("mti_mepc", csr_rdata, 64'h100);
        idle(12'h300);
        check("mti_mstatus", csr_rdata, 64'h1880);

        // ecall racing MEI+MSI: interrupt wins, then plain ecall once MIE is cleared.
        csrw(12'h300, 2'b10, 64'h8);
        csrw(12'h304, 2'b01, 64'h888);
        irq_v = 3'b101;
        idle(12'h000);
        step(1'b0, 1'b1, 64'h200, 12'h000, 2'b00, 64'd0, 1'b0, 4'b0001, 32'd0);
        check("ecall_irq_redirect", {63'd0, redirect}, 64'd1);
        idle(12'h342);
        check("ecall_irq_mcause", csr_rdata, 64'h8000_0000_0000_000B);
        idle(12'h341);
        check("ecall_irq_mepc", csr_rdata, 64'h200);
        step(1'b0, 1'b1, 64'h200, 12'h000, 2'b00, 64'd0, 1'b0, 4'b0001, 32'd0);
        check("ecall_retire", {63'd0, retire}, 64'd0);
        irq_v = 3'b000;
        idle(12'h342);
        check("ecall_mcause", csr_rdata, 64'd11);

        // Unknown CSR and suppressed read of a read-only CSR.
        step(1'b0, 1'b1, 64'h300, 12'h7C0, 2'b10, 64'h5, 1'b0, 4'd0, 32'h7C00_2073);
        check("unk_illegal", {63'd0, illegal_csr}, 64'd1);
        check("unk_rdata", csr_rdata, 64'd0);
        check("unk_pc", redirect_pc, 64'h8000_0000);
        idle(12'h342);
        check("unk_mcause", csr_rdata, 64'd2);
        idle(12'h343);
        check("unk_mtval", csr_rdata, 64'h7C00_2073);
        step(1'b0, 1'b1, 64'h304, 12'hF14, 2'b10, 64'd0, 1'b1, 4'd0, 32'd0);
        check("hartid_sup_illegal", {63'd0, illegal_csr}, 64'd0);
        check("hartid_sup_retire", {63'd0, retire}, 64'd1);

        // Counter wrap and minstret hold.
        csrw(12'hB00, 2'b01, ~64'd0);
        idle(12'hB00);
        check("mcycle_max", csr_rdata, ~64'd0);
        idle(12'hB00);
        check("mcycle_wrap", csr_rdata, 64'd0);
        csrw(12'hB02, 2'b01, 64'h1234);
        idle(12'hB02);
        check("minstret_set", csr_rdata, 64'h1234);
        step(1'b0, 1'b1, 64'h210, 12'hB02, 2'b00, 64'd0, 1'b0, 4'b0001, 32'd0);
        idle(12'hB02);
        check("minstret_trap_hold", csr_rdata, 64'h1234);

        // mret, then reset landing on an mret.
        csrw(12'h341, 2'b01, 64'h344);
        csrw(12'h300, 2'b01, 64'h80);
        step(1'b0, 1'b1, 64'h400, 12'h300, 2'b00, 64'd0, 1'b0, 4'b0100, 32'd0);
        check("mret_redirect", {63'd0, redirect}, 64'd1);
        check("mret_pc", redirect_pc, 64'h344);
        check("mret_retire", {63'd0, retire}, 64'd1);
        idle(12'h300);
        check("mret_mstatus", csr_rdata, 64'h1888);
        idle(12'hB02);
        check("mret_minstret", csr_rdata, 64'h1237);
        step(1'b1, 1'b1, 64'h400, 12'h300, 2'b00, 64'd0, 1'b0, 4'b0100, 32'd0);
        idle(12'h300);
        check("rst_mret_mstatus", csr_rdata, 64'h1800);
        check("rst_mret_redirect", {63'd0, redirect}, 64'd0);

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 15))
                0: cls = 4'b0001;
                1: cls = 4'b0010;
                2: cls = 4'b1000;
                3: cls = 4'b0100;
                default: cls = 4'b0000;
            endcase
            op = (cls == 4'b0100) ? 2'b00 : 2'($urandom_range(0, 3));
            irq_v = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) != 0),
                 {$urandom, $urandom}, idx_tab[$urandom_range(0, 15)], op,
                 ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 4095)),
                 ($urandom_range(0, 3) == 0), cls, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
